// File: rtl/uart_transmitter_controller.sv
// Return-path controller: buffers one register-file read and one ALU result, then serialises them as bytes into the TX FIFO.
// Optional macro RESPONSE_CHECKSUM_EN appends an XOR checksum byte to every response.
module uart_transmitter_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      read_data_valid,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic                      ALU_result_valid,
    input  logic [2*DATA_WIDTH-1:0]   ALU_result,
    input  logic                      fifo_full,
    output logic                      fifo_write_enable,
    output logic [DATA_WIDTH-1:0]     fifo_write_data,
    output logic                      busy,
    output logic                      response_dropped
);

`ifdef RESPONSE_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, SEND_READ, SEND_ALU_LOW, SEND_ALU_HIGH, SEND_CHECKSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, SEND_READ, SEND_ALU_LOW, SEND_ALU_HIGH
    } state_t;
`endif

    state_t                    state_reg;
    logic                      read_pending_reg;
    logic                      alu_pending_reg;
    logic [DATA_WIDTH-1:0]     read_buffer_reg;
    logic [2*DATA_WIDTH-1:0]   alu_buffer_reg;
    logic                      response_dropped_reg;
    logic                      write_fire;
    logic                      read_release;
    logic                      alu_release;
    logic                      read_capture;
    logic                      alu_capture;
    logic                      read_drop;
    logic                      alu_drop;

`ifdef RESPONSE_CHECKSUM_EN
    // Remembers which response the checksum byte belongs to.
    logic                      checksum_alu_reg;
`endif

    assign write_fire        = (state_reg != IDLE) && !fifo_full;
    assign fifo_write_enable = write_fire;
    assign busy              = (state_reg != IDLE) || read_pending_reg || alu_pending_reg;
    assign response_dropped  = response_dropped_reg;

    // A buffer is released on the edge that writes the final byte of its response.
`ifdef RESPONSE_CHECKSUM_EN
    assign read_release = write_fire && (state_reg == SEND_CHECKSUM) && !checksum_alu_reg;
    assign alu_release  = write_fire && (state_reg == SEND_CHECKSUM) &&  checksum_alu_reg;
`else
    assign read_release = write_fire && (state_reg == SEND_READ);
    assign alu_release  = write_fire && (state_reg == SEND_ALU_HIGH);
`endif

    assign read_capture = enable && read_data_valid  && (!read_pending_reg || read_release);
    assign read_drop    = enable && read_data_valid  &&   read_pending_reg && !read_release;
    assign alu_capture  = enable && ALU_result_valid && (!alu_pending_reg  || alu_release);
    assign alu_drop     = enable && ALU_result_valid &&   alu_pending_reg  && !alu_release;

    always_comb begin
        fifo_write_data = '0;
        case (state_reg)
            SEND_READ:     fifo_write_data = read_buffer_reg;
            SEND_ALU_LOW:  fifo_write_data = alu_buffer_reg[DATA_WIDTH-1:0];
            SEND_ALU_HIGH: fifo_write_data = alu_buffer_reg[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef RESPONSE_CHECKSUM_EN
            SEND_CHECKSUM: fifo_write_data = checksum_alu_reg
                                ? (alu_buffer_reg[DATA_WIDTH-1:0] ^ alu_buffer_reg[2*DATA_WIDTH-1:DATA_WIDTH])
                                : read_buffer_reg;
`endif
            default:       fifo_write_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= IDLE;
            read_pending_reg     <= 1'b0;
            alu_pending_reg      <= 1'b0;
            read_buffer_reg      <= '0;
            alu_buffer_reg       <= '0;
            response_dropped_reg <= 1'b0;
`ifdef RESPONSE_CHECKSUM_EN
            checksum_alu_reg     <= 1'b0;
`endif
        end else begin
            response_dropped_reg <= read_drop || alu_drop;

            // A capture on the release edge wins over clearing the flag.
            if (read_capture) begin
                read_buffer_reg  <= read_data;
                read_pending_reg <= 1'b1;
            end else if (read_release) begin
                read_pending_reg <= 1'b0;
            end

            if (alu_capture) begin
                alu_buffer_reg  <= ALU_result;
                alu_pending_reg <= 1'b1;
            end else if (alu_release) begin
                alu_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (read_pending_reg) begin
                        state_reg <= SEND_READ;
                    end else if (alu_pending_reg) begin
                        state_reg <= SEND_ALU_LOW;
                    end
                end
                SEND_READ: begin
                    if (write_fire) begin
`ifdef RESPONSE_CHECKSUM_EN
                        state_reg        <= SEND_CHECKSUM;
                        checksum_alu_reg <= 1'b0;
`else
                        state_reg        <= IDLE;
`endif
                    end
                end
                SEND_ALU_LOW: begin
                    if (write_fire) begin
                        state_reg <= SEND_ALU_HIGH;
                    end
                end
                SEND_ALU_HIGH: begin
                    if (write_fire) begin
`ifdef RESPONSE_CHECKSUM_EN
                        state_reg        <= SEND_CHECKSUM;
                        checksum_alu_reg <= 1'b1;
`else
                        state_reg        <= IDLE;
`endif
                    end
                end
`ifdef RESPONSE_CHECKSUM_EN
                SEND_CHECKSUM: begin
                    if (write_fire) begin
                        state_reg <= IDLE;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Bench for uart_transmitter_controller: queue-based response model checked every cycle, plus directed literal checks.
module tb_uart_transmitter_controller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        read_data_valid;
    logic [7:0]  read_data;
    logic        ALU_result_valid;
    logic [15:0] ALU_result;
    logic        fifo_full;
    logic        fifo_write_enable;
    logic [7:0]  fifo_write_data;
    logic        busy;
    logic        response_dropped;

    uart_transmitter_controller #(.DATA_WIDTH(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .read_data_valid   (read_data_valid),
        .read_data         (read_data),
        .ALU_result_valid  (ALU_result_valid),
        .ALU_result        (ALU_result),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .busy              (busy),
        .response_dropped  (response_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending records plus the byte list of the response being sent.
    bit          m_rpend = 0, m_apend = 0, m_active = 0, m_src_alu = 0, m_drop = 0;
    logic [7:0]  m_rbuf = 0;
    logic [15:0] m_abuf = 0;
    logic [7:0]  m_q[$];
    bit          m_we, m_last, r_cap, a_cap, r_drop, a_drop, old_r, old_a;

    logic [7:0]  wlog[$];
    logic [7:0]  elog[$];
    int          drops = 0;

    // Compare current outputs, then advance the model with the inputs sampled at the next edge.
    always @(negedge clk) begin
        m_we = m_active && !fifo_full;
        chk("cyc_we",   fifo_write_enable, m_we);
        chk("cyc_data", fifo_write_data,   m_active ? m_q[0] : 8'h00);
        chk("cyc_busy", busy,              m_active || m_rpend || m_apend);
        chk("cyc_drop", response_dropped,  m_drop);
        if (fifo_write_enable === 1'b1) begin
            wlog.push_back(fifo_write_data);
            $display("tx byte 0x%02h at %0t", fifo_write_data, $time);
        end
        if (response_dropped === 1'b1) drops++;

        if (reset) begin
            m_rpend = 0; m_apend = 0; m_active = 0; m_src_alu = 0; m_drop = 0;
            m_rbuf = 0; m_abuf = 0; m_q.delete();
        end else begin
            m_last = m_we && (m_q.size() == 1);
            r_cap = 0; a_cap = 0; r_drop = 0; a_drop = 0;
            if (enable && read_data_valid) begin
                if (!m_rpend || (m_last && !m_src_alu)) r_cap = 1; else r_drop = 1;
            end
            if (enable && ALU_result_valid) begin
                if (!m_apend || (m_last && m_src_alu)) a_cap = 1; else a_drop = 1;
            end
            old_r = m_rpend;
            old_a = m_apend;
            if (m_active) begin
                if (m_we) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_active = 0;
                        if (m_src_alu) m_apend = 0; else m_rpend = 0;
                    end
                end
            end else if (old_r) begin
                m_active = 1; m_src_alu = 0;
                m_q.push_back(m_rbuf);
`ifdef RESPONSE_CHECKSUM_EN
                m_q.push_back(m_rbuf);
`endif
            end else if (old_a) begin
                m_active = 1; m_src_alu = 1;
                m_q.push_back(m_abuf[7:0]);
                m_q.push_back(m_abuf[15:8]);
`ifdef RESPONSE_CHECKSUM_EN
                m_q.push_back(m_abuf[7:0] ^ m_abuf[15:8]);
`endif
            end
            if (r_cap) begin m_rbuf = read_data;  m_rpend = 1; end
            if (a_cap) begin m_abuf = ALU_result; m_apend = 1; end
            m_drop = r_drop || a_drop;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, wlog.size(), elog.size());
        for (int i = 0; i < elog.size(); i++) begin
            if (i < wlog.size()) chk({name, "_byte"}, wlog[i], elog[i]);
        end
        wlog.delete();
        elog.delete();
    endtask

    initial begin
        reset = 1; enable = 0; read_data_valid = 0; read_data = 0;
        ALU_result_valid = 0; ALU_result = 0; fifo_full = 0;
        step(2);
        reset = 0;
        @(negedge clk);
        chk("rst_we",   fifo_write_enable, 0);
        chk("rst_data", fifo_write_data,   0);
        chk("rst_busy", busy,              0);
        chk("rst_drop", response_dropped,  0);
        step();
        enable = 1;
        wlog.delete();

        // single read response, two-cycle latency
        read_data_valid = 1; read_data = 8'h5A;
        step();
        read_data_valid = 0;
        @(negedge clk);
        chk("t1_we_early", fifo_write_enable, 0);
        step();
        @(negedge clk);
        chk("t1_we",   fifo_write_enable, 1);
        chk("t1_data", fifo_write_data,   8'h5A);
        step();
        @(negedge clk);
`ifdef RESPONSE_CHECKSUM_EN
        chk("t1_cs", fifo_write_data, 8'h5A);
`else
        chk("t1_busy_done", busy, 0);
`endif
        step(4);
        elog = {8'h5A};
`ifdef RESPONSE_CHECKSUM_EN
        elog.push_back(8'h5A);
`endif
        check_log("t1_log");

        // ALU split low then high
        ALU_result_valid = 1; ALU_result = 16'h1234;
        step();
        ALU_result_valid = 0;
        step(7);
        elog = {8'h34, 8'h12};
`ifdef RESPONSE_CHECKSUM_EN
        elog.push_back(8'h26);
`endif
        check_log("t2_log");

        // simultaneous read and ALU, read first
        drops = 0;
        read_data_valid = 1; read_data = 8'hA5;
        ALU_result_valid = 1; ALU_result = 16'hBEEF;
        step();
        read_data_valid = 0; ALU_result_valid = 0;
        step(10);
        elog = {8'hA5};
`ifdef RESPONSE_CHECKSUM_EN
        elog.push_back(8'hA5);
`endif
        elog.push_back(8'hEF);
        elog.push_back(8'hBE);
`ifdef RESPONSE_CHECKSUM_EN
        elog.push_back(8'h51);
`endif
        check_log("t3_log");
        chk("t3_drops", drops, 0);

        // stall on first write cycle of ALU 0x00FF
        ALU_result_valid = 1; ALU_result = 16'h00FF;
        step();
        ALU_result_valid = 0;
        step();
        fifo_full = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_we",   fifo_write_enable, 0);
            chk("t4_stall_data", fifo_write_data,   8'hFF);
            step();
        end
        fifo_full = 0;
        step(6);
        elog = {8'hFF, 8'h00};
`ifdef RESPONSE_CHECKSUM_EN
        elog.push_back(8'hFF);
`endif
        check_log("t4_log");

        // second read while the first is pending is dropped
        drops = 0;
        fifo_full = 1;
        read_data_valid = 1; read_data = 8'h11;
        step();
        read_data = 8'h22;
        step();
        read_data_valid = 0;
        @(negedge clk);
        chk("t5_drop_pulse", response_dropped, 1);
        chk("t5_data_held",  fifo_write_data,  8'h11);
        step(3);
        fifo_full = 0;
        step(6);
        elog = {8'h11};
`ifdef RESPONSE_CHECKSUM_EN
        elog.push_back(8'h11);
`endif
        check_log("t5_log");
        chk("t5_drops", drops, 1);

        // disabled capture
        drops = 0;
        enable = 0;
        read_data_valid = 1; read_data = 8'h33;
        step();
        read_data_valid = 0;
        step(5);
        check_log("t5b_log");
        chk("t5b_drops", drops, 0);
        enable = 1;

        // reset while stalled in the high-byte state
        ALU_result_valid = 1; ALU_result = 16'hCDAB;
        step();
        ALU_result_valid = 0;
        step(2);
        fifo_full = 1;
        @(negedge clk);
        chk("t6_high_data", fifo_write_data, 8'hCD);
        reset = 1;
        step();
        reset = 0; fifo_full = 0;
        @(negedge clk);
        chk("t6_rst_we",   fifo_write_enable, 0);
        chk("t6_rst_data", fifo_write_data,   0);
        chk("t6_rst_busy", busy,              0);
        step(5);
        elog = {8'hAB};
        check_log("t6_log");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter_controller.md
Name: uart_transmitter_controller

Overview:
- Return-path controller of the system controller: collects register-file read data and ALU results and serialises them as bytes into the TX asynchronous FIFO that feeds the UART transmitter.
- Arbitrates between the two response sources and holds one pending response of each type.
- Splits the 2*DATA_WIDTH ALU result into low byte then high byte.
- Stalls on FIFO full without losing data.

Parameters:
- DATA_WIDTH, 8, width of the UART frame and the register-file word.

Ports:
- clk  input  1  reference clock (40 MHz domain).
- reset  input  1  synchronous, active-high reset.
- enable  input  1  capture enable for new responses.
- read_data_valid  input  1  single-cycle pulse: read_data is valid.
- read_data  input  DATA_WIDTH  register-file read data.
- ALU_result_valid  input  1  single-cycle pulse: ALU_result is valid.
- ALU_result  input  2*DATA_WIDTH  ALU output.
- fifo_full  input  1  TX FIFO full.
- fifo_write_enable  output  1  FIFO write strobe.
- fifo_write_data  output  DATA_WIDTH  byte to FIFO.
- busy  output  1  state != IDLE or any pending flag set.
- response_dropped  output  1  one-cycle pulse: a response was discarded.

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk): state=IDLE; read_pending=0, alu_pending=0; both buffers=0; fifo_write_enable=0, fifo_write_data=0, busy=0, response_dropped=0. Reset mid-response aborts it; remaining bytes are never written.
- Capture (only when enable=1): at a clock edge where read_data_valid=1 and read_pending=0, set read_buffer<=read_data and read_pending<=1. The ALU path works the same way with alu_buffer and alu_pending.
- A valid pulse arriving while its own pending flag is set, and the buffer is not being released in that cycle, is dropped. The buffer keeps its old value and response_dropped=1 for the next cycle.
- When enable=0, valid pulses are ignored (no drop pulse). In-flight and pending responses still complete.
- FSM states: IDLE, SEND_READ, SEND_ALU_LOW, SEND_ALU_HIGH (plus SEND_CHECKSUM with the optional feature).
- IDLE: if read_pending, go to SEND_READ; else if alu_pending, go to SEND_ALU_LOW. Read data has fixed priority when both are pending.
- fifo_write_enable = (state != IDLE) && !fifo_full, combinational.
- fifo_write_data by state: read_buffer in SEND_READ; alu_buffer[DATA_WIDTH-1:0] in SEND_ALU_LOW; alu_buffer[2*DATA_WIDTH-1:DATA_WIDTH] in SEND_ALU_HIGH. It is held stable during a stall.
- A state advances only on an edge with fifo_write_enable=1:
  - SEND_READ -> IDLE, clearing read_pending.
  - SEND_ALU_LOW -> SEND_ALU_HIGH.
  - SEND_ALU_HIGH -> IDLE, clearing alu_pending.
- The pending flag clears on the same edge as the last byte write. A valid pulse on that same edge is captured, not dropped.
- Latency: valid in cycle c gives pending set after edge c and state change after edge c+1. fifo_write_enable goes high in cycle c+2 if the FIFO is not full.
- Throughput: one byte per cycle. One IDLE cycle separates consecutive responses.
- fifo_full=1 freezes the state and data; nothing is lost. Captures continue during a stall.

Optional Feature:
- RESPONSE_CHECKSUM_EN defined: the last data byte of each response goes to SEND_CHECKSUM instead of IDLE. SEND_CHECKSUM emits the XOR of that response's bytes (read: read_buffer; ALU: low^high), then goes to IDLE.
- In this mode the pending flag clears on the checksum write.
- Undefined: no checksum state; responses are exactly 1 or 2 bytes.

Test Plan:
- Reset, enable=1, read_data_valid pulse with 0x5A -> single write 0x5A two cycles later; busy returns to 0 the following cycle.
- ALU_result_valid with 0x1234 -> consecutive writes 0x34 then 0x12; with RESPONSE_CHECKSUM_EN, followed by 0x26.
- Same-cycle read_data_valid (0xA5) and ALU_result_valid (0xBEEF) -> writes 0xA5, then after one IDLE cycle 0xEF, 0xBE; no drop.
- ALU 0x00FF with fifo_full=1 held for 5 cycles from the first write cycle -> fifo_write_enable=0 throughout, data held at 0xFF; after release, writes 0xFF, 0x00.
- Two read_data_valid pulses (0x11, 0x22) while fifo_full=1 -> 0x22 dropped with a response_dropped pulse; only 0x11 is written after release. With enable=0, a pulse of 0x33 produces no write and no drop.
- Reset asserted in SEND_ALU_HIGH -> high byte never written; all outputs 0 after the reset edge, pending flags cleared.
